// File: rtl/miner_pkg.sv
// Shared definitions for the mining nonce scheduler: state encoding,
// header geometry and job completion codes.
package miner_pkg;

    localparam int HDR_WORDS = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_RDY,
        ST_START,
        ST_FEED,
        ST_RUN,
        ST_STOP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        STAT_NONE      = 2'b00,
        STAT_FOUND     = 2'b01,
        STAT_EXHAUSTED = 2'b10,
        STAT_ABORTED   = 2'b11
    } status_e;

endpackage

// File: rtl/hdr_buf.sv
// Block header register file: written word by word while loading from the
// host FIFO, read combinationally while the header is fed to the cores.
module hdr_buf #(
    parameter int WORDS = 20,
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nonce_sched.sv
// Job scheduler for a bank of nonce cores: loads one block header, broadcasts
// it, then collects the winning nonce or stops the job on abort/exhaustion.
module nonce_sched #(
    parameter int NUM_CORES = 4,
    parameter int HDR_WORDS = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          hdr_fifo_dout,
    input  logic                 hdr_fifo_empty,
    output logic                 hdr_fifo_re,
    output logic                 core_start,
    output logic                 core_stop,
    output logic [31:0]          core_block_header,
    input  logic [NUM_CORES-1:0] core_stop_ack,
    input  logic                 abort,
    input  logic                 golden_valid,
    input  logic [31:0]          golden_nonce,
    output logic                 golden_ready,
    output logic [31:0]          res_fifo_din,
    output logic                 res_fifo_we,
    input  logic                 res_fifo_full,
    output logic                 job_done,
    output logic [1:0]           job_status,
    output logic [15:0]          job_count,
    output logic [2:0]           dbg_state
);

    import miner_pkg::*;

    localparam int AW = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
    localparam int CW = $clog2(HDR_WORDS + 1);

    state_e        state;
    status_e       pend_status;
    logic [CW-1:0] cnt;
    logic          abort_lat;
    logic          all_idle;
    logic          pop;
    logic          last_word;
    logic          accept;
    logic [31:0]   rd_word;

    // Golden handshake: a nonce transfers on any cycle where golden_valid and
    // golden_ready are both high; only transfers in RUN reach the result FIFO.
    assign all_idle  = &core_stop_ack;
    assign pop       = (state == ST_LOAD) && !hdr_fifo_empty && !rst;
    assign last_word = (cnt == CW'(HDR_WORDS - 1));
    assign accept    = (state == ST_RUN) && golden_valid && !res_fifo_full && !rst;

    assign hdr_fifo_re       = pop;
    assign core_start        = (state == ST_START);
    assign core_stop         = (state == ST_STOP);
    assign core_block_header = (state == ST_FEED) ? rd_word : 32'h0;
    assign golden_ready      = ((state == ST_RUN) && !res_fifo_full) || (state == ST_STOP);
    assign res_fifo_we       = accept;
    assign res_fifo_din      = accept ? golden_nonce : 32'h0;
    assign job_done          = (state == ST_DONE);
    assign dbg_state         = state;

    hdr_buf #(
        .WORDS(HDR_WORDS)
    ) u_hdr_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (pop),
        .waddr(cnt[AW-1:0]),
        .wdata(hdr_fifo_dout),
        .raddr(cnt[AW-1:0]),
        .rdata(rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pend_status <= STAT_NONE;
            cnt         <= '0;
            abort_lat   <= 1'b0;
            job_status  <= 2'b00;
            job_count   <= 16'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!hdr_fifo_empty) begin
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (pop) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) state <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (all_idle) state <= ST_START;
                end
                ST_START: begin
                    cnt   <= '0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    // Abort cannot cut a header broadcast short; it is acted on in RUN.
                    if (abort) abort_lat <= 1'b1;
                    cnt <= cnt + 1'b1;
                    if (last_word) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (accept) begin
                        pend_status <= STAT_FOUND;
                        state       <= ST_STOP;
                    end else if (abort || abort_lat) begin
                        pend_status <= STAT_ABORTED;
                        state       <= ST_STOP;
                    end else if (all_idle) begin
                        job_status <= STAT_EXHAUSTED;
                        state      <= ST_DONE;
                    end
                end
                ST_STOP: begin
                    if (all_idle) begin
                        job_status <= pend_status;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    job_count <= job_count + 16'h1;
                    abort_lat <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nonce_sched.md
NONCE_SCHED -- requirements
Module: nonce_sched

Interface
REQ-001 Parameter NUM_CORES, default 4, meaning number of nonce generator cores driven in parallel (1..16).
REQ-002 Parameter HDR_WORDS, default 20, meaning 32-bit words per 80-byte block header.
REQ-003 clk  input  1  global clock; single clock domain.
REQ-004 rst  input  1  global reset, synchronous, active-high.
REQ-005 hdr_fifo_dout  input  32  header word from host header FIFO (first-word-fall-through).
REQ-006 hdr_fifo_empty  input  1  header FIFO empty flag.
REQ-007 hdr_fifo_re  output  1  header FIFO pop.
REQ-008 core_start  output  1  start pulse broadcast to all cores.
REQ-009 core_stop  output  1  stop level broadcast to all cores.
REQ-010 core_block_header  output  32  header word bus shared by all cores.
REQ-011 core_stop_ack  input  NUM_CORES  per-core idle/ready flag (1 = core in INIT).
REQ-012 abort  input  1  host abort request, level.
REQ-013 golden_valid  input  1  hash checker reports a winning nonce.
REQ-014 golden_nonce  input  32  winning nonce value.
REQ-015 golden_ready  output  1  scheduler accepts golden_nonce this cycle.
REQ-016 res_fifo_din  output  32  result FIFO data.
REQ-017 res_fifo_we  output  1  result FIFO write enable.
REQ-018 res_fifo_full  input  1  result FIFO full flag.
REQ-019 job_done  output  1  one-cycle pulse at job end.
REQ-020 job_status  output  2  01 found, 10 exhausted, 11 aborted; valid with job_done, held until next job_done.
REQ-021 job_count  output  16  completed jobs, wraps 0xFFFF->0.

Function
REQ-022 States IDLE, LOAD, WAIT_RDY, START, FEED, RUN, STOP, DONE; registered state, combinational outputs.
REQ-023 IDLE: if !hdr_fifo_empty -> LOAD, word counter cleared.
REQ-024 LOAD: hdr_fifo_re=1 only when !hdr_fifo_empty; each pop stores dout at buffer[cnt], cnt+1; empty stalls without loss; after HDR_WORDS pops -> WAIT_RDY.
REQ-025 WAIT_RDY: when core_stop_ack all ones -> START; otherwise wait indefinitely.
REQ-026 START: core_start=1 for exactly one cycle (cycle T), cnt cleared -> FEED.
REQ-027 FEED: core_block_header=buffer[cnt] on cycles T+1..T+HDR_WORDS, word 0 at T+1; then -> RUN at T+HDR_WORDS+1.
REQ-028 core_block_header = 0 outside FEED.
REQ-029 RUN: golden_ready = !res_fifo_full; on golden_valid&&golden_ready write golden_nonce to result FIFO same cycle, status found, -> STOP.
REQ-030 RUN: abort (or abort latched during FEED) with no accepted golden -> status aborted, -> STOP; golden has priority over abort in same cycle.
REQ-031 RUN: core_stop_ack all ones with no golden/abort -> status exhausted, -> DONE.
REQ-032 STOP: core_stop=1 held until core_stop_ack all ones, then -> DONE; golden_ready=1, stragglers accepted and discarded (no FIFO write).
REQ-033 DONE: job_done=1 one cycle, job_count+1, -> IDLE.
REQ-034 abort in IDLE, LOAD, WAIT_RDY, START ignored; abort in FEED latched, cleared in DONE.
REQ-035 golden_ready=0 in all states except RUN and STOP.

Reset
REQ-036 rst: state IDLE, counters, buffer, abort latch, job_status, job_count cleared; all outputs 0 in cycle after rst.
REQ-037 rst mid-job abandons job without job_done; no FIFO pop or write during rst.

Structure
REQ-038 Shared package miner_pkg: state enum, HDR_WORDS, status codes.
REQ-039 Sub-module hdr_buf: HDR_WORDS x 32 register file, write port (LOAD), read port (FEED).

Verification
REQ-040 Header 0x00000001..0x00000014 preloaded, cores idle -> 20 pops, start at T, word k on T+1+k, RUN at T+21.
REQ-041 Empty FIFO for 5 cycles after word 7 -> no extra pops, buffer words 8..20 intact.
REQ-042 RUN, golden_valid nonce 0xDEADBEEF -> one FIFO write 0xDEADBEEF, core_stop until all acks, job_done status 01.
REQ-043 RUN, res_fifo_full=1 with golden_valid -> golden_ready=0, no write; full drops -> accepted next cycle.
REQ-044 abort pulse during FEED -> RUN then STOP next cycle, job_status 11; all acks rise -> cores exhaust, status 10.
REQ-045 job_count preset 0xFFFF via 65535 short jobs (or force) -> next job_done wraps to 0x0000.
